// File: rtl/conv_ctrl.sv
// conv_ctrl: address sequencer that sits directly upstream of conv_unit.
//
// Walks a stride-1 KSIZE x KSIZE convolution over a C x H x W feature map held
// in flat memories. Each output pixel takes C*KSIZE*KSIZE product cycles
// followed by exactly one bias cycle, with no bubbles in between. Loop order,
// outermost first: m, oy, ox, then the taps c, ky, kx.
// Read addresses go out in the address cycle. conv_en, conv_set_b and conv_wa
// are registered one cycle later so they line up with the 1-cycle read data.
//
// Optional feature (macro CONV_CTRL_PAD_EN): same-padding of (KSIZE-1)/2 on
// every edge. Taps that fall outside the image read PAD_ZERO_ADDR instead.
//
// Ports:
//   clk, rst (async, active-low)  clock and reset
//   start                         one-cycle pulse, accepted only in IDLE
//   pause                         hold at the next pixel boundary
//   in_w/in_h/in_c/out_c          layer dimensions W, H, C, M (latched on start)
//   in_base/w_base/b_base/out_base region base addresses (latched on start)
//   in_ra/w_ra/b_ra               memory read addresses (0 when not issuing)
//   conv_en/conv_set_b/conv_wa    conv_unit en / set_b / out_wa_in
//   busy, done, err               status: in progress, done pulse, sticky bad config
//   dbg_state                     current FSM state
// There is no valid/ready handshake. start is a fire-and-forget pulse.
// It is dropped unless the controller is in IDLE.
module conv_ctrl #(
  parameter int MEM_SIZE      = 16,
  parameter int DIM_SIZE      = 8,
  parameter int KSIZE         = 3,
  parameter int PAD_ZERO_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic [DIM_SIZE-1:0] in_w,
  input  logic [DIM_SIZE-1:0] in_h,
  input  logic [DIM_SIZE-1:0] in_c,
  input  logic [DIM_SIZE-1:0] out_c,
  input  logic [MEM_SIZE-1:0] in_base,
  input  logic [MEM_SIZE-1:0] w_base,
  input  logic [MEM_SIZE-1:0] b_base,
  input  logic [MEM_SIZE-1:0] out_base,
  output logic [MEM_SIZE-1:0] in_ra,
  output logic [MEM_SIZE-1:0] w_ra,
  output logic [MEM_SIZE-1:0] b_ra,
  output logic                conv_en,
  output logic                conv_set_b,
  output logic [MEM_SIZE-1:0] conv_wa,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          dbg_state
);

  localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam logic [KW-1:0]       K_LAST = KW'(KSIZE - 1);
  localparam logic [MEM_SIZE-1:0] K_M    = MEM_SIZE'(KSIZE);
  localparam logic [DIM_SIZE-1:0] D_ONE  = DIM_SIZE'(1);
`ifdef CONV_CTRL_PAD_EN
  localparam logic [MEM_SIZE-1:0] PAD_M     = MEM_SIZE'((KSIZE - 1) / 2);
  localparam logic [MEM_SIZE-1:0] ZERO_ADDR = MEM_SIZE'(PAD_ZERO_ADDR);
`else
  localparam logic [DIM_SIZE-1:0] K_D = DIM_SIZE'(KSIZE);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [DIM_SIZE-1:0] cfg_w, cfg_h, cfg_c, cfg_m, cfg_ow, cfg_oh;
  logic [MEM_SIZE-1:0] cfg_in_base, cfg_w_base, cfg_b_base, cfg_out_base;
  logic [DIM_SIZE-1:0] m, oy, ox, c;
  logic [KW-1:0]       ky, kx;
  logic                bias_ph;    // current address cycle is the bias cycle
  logic [1:0]          drain_cnt;
  logic                cfg_bad, last_px, issue;
  logic [MEM_SIZE-1:0] row_a, col_a, plane_a, in_addr, w_addr, wa_addr;

  function automatic logic [MEM_SIZE-1:0] ext_d(input logic [DIM_SIZE-1:0] v);
    return MEM_SIZE'(v);
  endfunction

  always_comb begin
    cfg_bad = (in_w == '0) || (in_h == '0) || (in_c == '0) || (out_c == '0);
`ifndef CONV_CTRL_PAD_EN
    cfg_bad = cfg_bad || (in_w < K_D) || (in_h < K_D);
`endif
  end

  assign last_px = (ox == cfg_ow - D_ONE) && (oy == cfg_oh - D_ONE) &&
                   (m == cfg_m - D_ONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = cfg_bad ? S_DONE : S_RUN;
      S_RUN:   if (bias_ph) begin
                 if (last_px)    state_nx = S_DRAIN;
                 else if (pause) state_nx = S_PAUSE;
               end
      S_PAUSE: if (!pause) state_nx = S_RUN;
      // The bias word enters conv_unit one cycle after its address cycle and
      // takes 3 more stages to reach out_we_d2, so done lands 4 cycles after it.
      S_DRAIN: if (drain_cnt == 2'd2) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Address generation, all arithmetic wraps at MEM_SIZE bits
  always_comb begin
    row_a   = ext_d(oy) + MEM_SIZE'(ky);
    col_a   = ext_d(ox) + MEM_SIZE'(kx);
    plane_a = ext_d(c) * ext_d(cfg_w) * ext_d(cfg_h);
`ifdef CONV_CTRL_PAD_EN
    // row_a/col_a are offset by the pad, so anything below PAD_M or at or
    // beyond size+PAD_M lies outside the image.
    if ((row_a < PAD_M) || (row_a >= ext_d(cfg_h) + PAD_M) ||
        (col_a < PAD_M) || (col_a >= ext_d(cfg_w) + PAD_M))
      in_addr = ZERO_ADDR;
    else
      in_addr = cfg_in_base + plane_a + (row_a - PAD_M) * ext_d(cfg_w) +
                (col_a - PAD_M);
`else
    in_addr = cfg_in_base + plane_a + row_a * ext_d(cfg_w) + col_a;
`endif
    w_addr  = cfg_w_base +
              ((ext_d(m) * ext_d(cfg_c) + ext_d(c)) * K_M + MEM_SIZE'(ky)) * K_M +
              MEM_SIZE'(kx);
    wa_addr = cfg_out_base + ext_d(m) * ext_d(cfg_ow) * ext_d(cfg_oh) +
              ext_d(oy) * ext_d(cfg_ow) + ext_d(ox);
  end

  // Output logic
  always_comb begin
    issue     = (state == S_RUN);
    busy      = (state == S_RUN) || (state == S_PAUSE) || (state == S_DRAIN);
    done      = (state == S_DONE);
    dbg_state = state;
    in_ra     = issue ? in_addr : '0;
    w_ra      = issue ? w_addr : '0;
    b_ra      = issue ? (cfg_b_base + ext_d(m)) : '0;
  end

  // Config capture, loop counters and the aligned conv_unit controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_w <= '0; cfg_h <= '0; cfg_c <= '0; cfg_m <= '0;
      cfg_ow <= '0; cfg_oh <= '0;
      cfg_in_base <= '0; cfg_w_base <= '0; cfg_b_base <= '0; cfg_out_base <= '0;
      m <= '0; oy <= '0; ox <= '0; c <= '0; ky <= '0; kx <= '0;
      bias_ph    <= 1'b0;
      drain_cnt  <= '0;
      err        <= 1'b0;
      conv_en    <= 1'b0;
      conv_set_b <= 1'b0;
      conv_wa    <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        cfg_w <= in_w; cfg_h <= in_h; cfg_c <= in_c; cfg_m <= out_c;
`ifdef CONV_CTRL_PAD_EN
        cfg_ow <= in_w;
        cfg_oh <= in_h;
`else
        cfg_ow <= in_w - K_D + D_ONE;
        cfg_oh <= in_h - K_D + D_ONE;
`endif
        cfg_in_base <= in_base; cfg_w_base <= w_base;
        cfg_b_base <= b_base; cfg_out_base <= out_base;
        m <= '0; oy <= '0; ox <= '0; c <= '0; ky <= '0; kx <= '0;
        bias_ph <= 1'b0;
        err     <= cfg_bad;
      end else if (state == S_RUN) begin
        if (!bias_ph) begin
          if (kx != K_LAST) kx <= kx + KW'(1);
          else begin
            kx <= '0;
            if (ky != K_LAST) ky <= ky + KW'(1);
            else begin
              ky <= '0;
              if (c != cfg_c - D_ONE) c <= c + D_ONE;
              else begin
                c       <= '0;
                bias_ph <= 1'b1;
              end
            end
          end
        end else begin
          // Pixel finished: step to the next pixel. PAUSE resumes from here.
          bias_ph <= 1'b0;
          if (ox != cfg_ow - D_ONE) ox <= ox + D_ONE;
          else begin
            ox <= '0;
            if (oy != cfg_oh - D_ONE) oy <= oy + D_ONE;
            else begin
              oy <= '0;
              m  <= (m != cfg_m - D_ONE) ? m + D_ONE : '0;
            end
          end
        end
      end

      drain_cnt  <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      conv_en    <= issue;
      conv_set_b <= issue && bias_ph;
      if (issue) conv_wa <= wa_addr;
    end
  end

endmodule
